// File: rtl/booth_radix4_controller.sv
// Sequencer for a radix-4 Booth shift-and-add multiplier datapath: LOAD, EVAL/SHIFT per digit, FINISH.
// Optional build macro BOOTH_SKIP_ZERO_DIGIT_EN folds zero-digit EVAL cycles into a shift.
module booth_radix4_controller #(
  parameter int size = 8
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       START,
  input  logic [2:0] control,
  output logic [1:0] accu_operatinal_mode_selector,
  output logic       accu_double,
  output logic       register_M_enable,
  output logic       shifter_LO_enable,
  output logic       shifter_HI_enable,
  output logic       shifter_X_enable,
  output logic       shifter_LO_operational_mode,
  output logic       shifter_HI_operational_mode,
  output logic       shifter_HI_clear,
  output logic       shifter_LO_clear,
  output logic       shifter_X_clear,
  output logic       BUSY,
  output logic       DONE
);

  localparam int ITER = size / 2;
  localparam int CW   = $clog2(ITER) + 1;
  localparam logic [CW-1:0] ITER_C = CW'(ITER);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_EVAL   = 3'd2,
    ST_SHIFT  = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  state_t          state_r, next_state_s;
  logic [CW-1:0]   count_r, count_next_s, count_inc_s;
  logic            last_s;
  logic [2:0]      digit_ctl_s;

  // Booth digit {q1,q0,q-1} -> {selector[1:0], double}
  function automatic logic [2:0] booth_decode(input logic [2:0] code);
    logic [2:0] res;
    case (code)
      3'b000, 3'b111: res = 3'b000;
      3'b001, 3'b010: res = 3'b010;
      3'b011:         res = 3'b011;
      3'b100:         res = 3'b101;
      3'b101, 3'b110: res = 3'b100;
      default:        res = 3'b000;
    endcase
    return res;
  endfunction

  assign count_inc_s = count_r + {{(CW-1){1'b0}}, 1'b1};
  assign last_s      = (count_inc_s == ITER_C);
  assign digit_ctl_s = booth_decode(control);

  // State and iteration counter registers
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_r <= ST_IDLE;
      count_r <= {CW{1'b0}};
    end else begin
      state_r <= next_state_s;
      count_r <= count_next_s;
    end
  end

  // Next-state and output decode
  always_comb begin
    next_state_s                  = state_r;
    count_next_s                  = count_r;
    accu_operatinal_mode_selector = 2'b00;
    accu_double                   = 1'b0;
    register_M_enable             = 1'b0;
    shifter_LO_enable             = 1'b0;
    shifter_HI_enable             = 1'b0;
    shifter_X_enable              = 1'b0;
    shifter_LO_operational_mode   = 1'b0;
    shifter_HI_operational_mode   = 1'b0;
    shifter_HI_clear              = 1'b0;
    shifter_LO_clear              = 1'b0;
    shifter_X_clear               = 1'b0;
    BUSY                          = 1'b0;
    DONE                          = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (START) begin
          next_state_s = ST_LOAD;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        register_M_enable = 1'b1;
        shifter_LO_enable = 1'b1;
        shifter_HI_clear  = 1'b1;
        shifter_X_clear   = 1'b1;
        BUSY              = 1'b1;
        count_next_s      = {CW{1'b0}};
        next_state_s      = ST_EVAL;
      end
      ST_EVAL: begin
        BUSY = 1'b1;
`ifdef BOOTH_SKIP_ZERO_DIGIT_EN
        // A zero digit needs no accumulate, so this cycle performs the shift directly
        if ((control == 3'b000) || (control == 3'b111)) begin
          shifter_HI_enable           = 1'b1;
          shifter_LO_enable           = 1'b1;
          shifter_HI_operational_mode = 1'b1;
          shifter_LO_operational_mode = 1'b1;
          shifter_X_enable            = 1'b1;
          count_next_s                = count_inc_s;
          if (last_s) begin
            next_state_s = ST_FINISH;
          end else begin
            next_state_s = ST_EVAL;
          end
        end else begin
          shifter_HI_enable             = 1'b1;
          accu_operatinal_mode_selector = digit_ctl_s[2:1];
          accu_double                   = digit_ctl_s[0];
          next_state_s                  = ST_SHIFT;
        end
`else
        shifter_HI_enable             = 1'b1;
        accu_operatinal_mode_selector = digit_ctl_s[2:1];
        accu_double                   = digit_ctl_s[0];
        next_state_s                  = ST_SHIFT;
`endif
      end
      ST_SHIFT: begin
        BUSY                        = 1'b1;
        shifter_HI_enable           = 1'b1;
        shifter_LO_enable           = 1'b1;
        shifter_HI_operational_mode = 1'b1;
        shifter_LO_operational_mode = 1'b1;
        shifter_X_enable            = 1'b1;
        count_next_s                = count_inc_s;
        if (last_s) begin
          next_state_s = ST_FINISH;
        end else begin
          next_state_s = ST_EVAL;
        end
      end
      ST_FINISH: begin
        DONE         = 1'b1;
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
        count_next_s = {CW{1'b0}};
      end
    endcase
  end

endmodule

// File: tb/tb_booth_radix4_controller.sv
// Scoreboard bench: a behavioural Booth datapath closes the loop around the controller;
// products and DONE latency are checked against plain multiplication and digit counts.
module tb_booth_radix4_controller;

  localparam int SIZE = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] control;
  logic [1:0] sel;
  logic       dbl, m_en, lo_en, hi_en, x_en, lo_mode, hi_mode, hi_clr, lo_clr, x_clr, busy, done;

  booth_radix4_controller #(.size(SIZE)) dut (
    .CLOCK(clk), .RESET(rst), .START(start), .control(control),
    .accu_operatinal_mode_selector(sel), .accu_double(dbl),
    .register_M_enable(m_en), .shifter_LO_enable(lo_en), .shifter_HI_enable(hi_en),
    .shifter_X_enable(x_en), .shifter_LO_operational_mode(lo_mode),
    .shifter_HI_operational_mode(hi_mode), .shifter_HI_clear(hi_clr),
    .shifter_LO_clear(lo_clr), .shifter_X_clear(x_clr), .BUSY(busy), .DONE(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural datapath: M, HI (with 2 guard bits), LO, X
  logic [7:0]         a_in = 8'd0, b_in = 8'd0;
  logic [7:0]         m_q = 8'd0, lo_q = 8'd0;
  logic signed [9:0]  hi_q = 10'sd0;
  logic               x_q = 1'b0;
  logic signed [9:0]  m_ext, m_mul, acc;
  logic signed [17:0] pair;

  assign control = {lo_q[1], lo_q[0], x_q};

  always_comb begin
    m_ext = {{2{m_q[7]}}, m_q};
    m_mul = dbl ? (m_ext <<< 1) : m_ext;
    case (sel)
      2'b01:   acc = hi_q + m_mul;
      2'b10:   acc = hi_q - m_mul;
      default: acc = hi_q;
    endcase
    pair = $signed({hi_q, lo_q}) >>> 2;
  end

  always @(posedge clk) begin
    if (m_en) m_q <= b_in;
    if (x_clr) x_q <= 1'b0;
    else if (x_en) x_q <= lo_q[1];
    if (hi_clr) hi_q <= 10'sd0;
    else if (hi_en) hi_q <= hi_mode ? pair[17:8] : acc;
    if (lo_clr) lo_q <= 8'd0;
    else if (lo_en) lo_q <= lo_mode ? pair[7:0] : a_in;
  end

  typedef struct {
    int prod;
    int start_cyc;
    int lat;
  } exp_t;
  exp_t sb_q[$];

  function automatic int digit_of(input logic [2:0] c);
    return -2 * int'(c[2]) + int'(c[1]) + int'(c[0]);
  endfunction

  function automatic int exp_lat(input logic [7:0] a);
    int z;
    logic [8:0] ax;
    z  = 0;
    ax = {a, 1'b0};
`ifdef BOOTH_SKIP_ZERO_DIGIT_EN
    for (int i = 0; i < SIZE / 2; i++)
      if (digit_of(ax[2*i+2 -: 3]) == 0) z++;
`endif
    return 2 + SIZE - z;
  endfunction

  // Monitor: checks digit decode in every accumulate cycle and the product on DONE
  int         busy_cnt = 0;
  logic [7:0] seen_mask = 8'h00;
  int         d_m, act_m, lat_m;
  logic [1:0] esel_m;
  logic       edbl_m;
  exp_t       e_m;
  always @(negedge clk) begin
    if (hi_en && !hi_mode) begin
      d_m    = digit_of(control);
      esel_m = (d_m > 0) ? 2'b01 : ((d_m < 0) ? 2'b10 : 2'b00);
      edbl_m = (d_m == 2) || (d_m == -2);
      tests++;
      if ({sel, dbl} !== {esel_m, edbl_m}) begin
        fails++;
        $display("FAIL decode ctl=%b sel/dbl=%b/%b required %b/%b", control, sel, dbl, esel_m, edbl_m);
      end
      seen_mask[control] = 1'b1;
    end
    if (done) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done at cycle %0d with empty scoreboard", cyc);
      end else begin
        e_m   = sb_q.pop_front();
        act_m = int'($signed({hi_q, lo_q}));
        lat_m = cyc - e_m.start_cyc;
        tests++;
        if (act_m != e_m.prod) begin
          fails++;
          $display("FAIL product got %0d required %0d", act_m, e_m.prod);
        end
        tests++;
        if (lat_m != e_m.lat) begin
          fails++;
          $display("FAIL latency got %0d required %0d", lat_m, e_m.lat);
        end
        tests++;
        if (busy_cnt != e_m.lat - 1) begin
          fails++;
          $display("FAIL busy_run got %0d required %0d", busy_cnt, e_m.lat - 1);
        end
      end
      busy_cnt = 0;
    end else if (busy) begin
      busy_cnt++;
    end else begin
      busy_cnt = 0;
    end
  end

  function automatic logic [13:0] out_vec();
    return {sel, dbl, m_en, lo_en, hi_en, x_en, lo_mode, hi_mode, hi_clr, lo_clr, x_clr, busy, done};
  endfunction

  task automatic check_idle(input string name);
    tests++;
    if (out_vec() !== 14'd0) begin
      fails++;
      $display("FAIL %s outputs=%b required all zero", name, out_vec());
    end
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    @(posedge clk);
    #1;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    sb_q.push_back('{int'($signed(a)) * int'($signed(b)), cyc, exp_lat(a)});
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 60);
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL %s timeout waiting for DONE after %0d cycles", name, n);
    end
  endtask

  initial begin
    int lat, n, ev;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset_state");

    issue(8'd3, 8'd5);
    wait_done("a3_b5");
    issue(8'h80, 8'h80);
    wait_done("neg128_sq");

    // RESET and START together: RESET wins
    @(posedge clk);
    #1;
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_idle("reset_with_start");

    // START held for 20 sampled edges: restarts only after each FINISH
    @(posedge clk);
    #1;
    a_in  = 8'h6B;
    b_in  = 8'hC4;
    start = 1'b1;
    lat   = exp_lat(8'h6B);
    for (int s = 0; s <= 19; s += lat + 1)
      sb_q.push_back('{int'($signed(8'h6B)) * int'($signed(8'hC4)), cyc + s, lat});
    repeat (20) @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (sb_q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL held_start pending=%0d required 0", sb_q.size());
    end

    // RESET during the third accumulate cycle
    issue(8'h55, 8'h12);
    ev = 0;
    n  = 0;
    while (ev < 3 && n < 40) begin
      @(negedge clk);
      n++;
      if (hi_en && !hi_mode) ev++;
    end
    tests++;
    if (ev != 3) begin
      fails++;
      $display("FAIL third_eval seen=%0d required 3", ev);
    end
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset_mid_op");
    issue(8'd7, 8'hFE);
    wait_done("a7_bm2");

    issue(8'd0, 8'd99);
    wait_done("a0_b99");
    issue(8'h7F, 8'h81);
    wait_done("a7f_b81");

    repeat (24) begin
      issue(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      wait_done("random");
    end

    tests++;
`ifdef BOOTH_SKIP_ZERO_DIGIT_EN
    if (seen_mask !== 8'h7E) begin
      fails++;
      $display("FAIL code_sweep mask=%b required %b", seen_mask, 8'h7E);
    end
`else
    if (seen_mask !== 8'hFF) begin
      fails++;
      $display("FAIL code_sweep mask=%b required %b", seen_mask, 8'hFF);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
